// File: rtl/ahbl_systick.sv
// AHB-Lite SysTick: 24-bit reloading down-counter behind a prescaler, CTRL/LOAD/VALUE/CALIB registers.
// Latency: zero-wait transfers; AHBL_SYSTICK_WS_EN adds exactly one wait state to every read.
// Backpressure: HREADYOUT drops only for that read wait state; HREADY gates address-phase capture.
module ahbl_systick #(
  parameter logic [31:0] CALIB_VAL = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  input  logic [23:0] SYSTICKCLKDIV,
  output logic        IRQ
);

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_LOAD  = 2'd1;
  localparam logic [1:0] A_VALUE = 2'd2;

  logic        addr_acc;
  logic        dp_vld;
  logic        dp_write;
  logic [3:0]  dp_addr;
  logic [2:0]  dp_size;

  logic        enable;
  logic        tickint;
  logic        countflag;
  logic [23:0] load_q;
  logic [23:0] value_q;
  logic [23:0] pre_cnt;

  logic        tick;
  logic        rd_act;
  logic        rd_ctrl;
  logic        wr_act;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_value;
  logic        cf_set;
  logic [3:0]  be;
  logic [23:0] wmask;
  logic [23:0] load_nxt;

  assign addr_acc = HSEL & HREADY & HTRANS[1];

  // Data-phase attributes only advance when the bus is ready, so they hold across a wait state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 4'd0;
      dp_size  <= 3'd0;
    end else if (HREADY) begin
      dp_vld   <= addr_acc;
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:0];
      dp_size  <= HSIZE;
    end
  end

`ifdef AHBL_SYSTICK_WS_EN
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  state_t state_nxt;
  logic   ready_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b1;
    case (state)
      S_IDLE: begin
        if (dp_vld && !dp_write) begin
          ready_c   = 1'b0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign HREADYOUT = ready_c;
  assign rd_act    = dp_vld & ~dp_write & (state == S_WAIT);
`else
  assign HREADYOUT = 1'b1;
  assign rd_act    = dp_vld & ~dp_write;
`endif

  assign wr_act   = dp_vld & dp_write;
  assign wr_ctrl  = wr_act & (dp_addr[3:2] == A_CTRL);
  assign wr_load  = wr_act & (dp_addr[3:2] == A_LOAD);
  assign wr_value = wr_act & (dp_addr[3:2] == A_VALUE);
  assign rd_ctrl  = rd_act & (dp_addr[3:2] == A_CTRL);

  always_comb begin
    be = 4'b0000;
    case (dp_size)
      3'd0:    be[dp_addr[1:0]] = 1'b1;
      3'd1:    be = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign wmask    = {{8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign load_nxt = (load_q & ~wmask) | (HWDATA[23:0] & wmask);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable  <= 1'b0;
      tickint <= 1'b0;
      load_q  <= 24'd0;
    end else begin
      if (wr_ctrl && be[0]) begin
        enable  <= HWDATA[0];
        tickint <= HWDATA[1];
      end
      if (wr_load) load_q <= load_nxt;
    end
  end

  // Prescaler free-runs; >= keeps it from running away if the divisor shrinks mid-count.
  assign tick = (pre_cnt >= SYSTICKCLKDIV);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)  pre_cnt <= 24'd0;
    else if (tick) pre_cnt <= 24'd0;
    else           pre_cnt <= pre_cnt + 24'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)              value_q <= 24'd0;
    else if (wr_value)         value_q <= 24'd0;
    else if (tick && enable)   value_q <= (value_q == 24'd0) ? load_q : value_q - 24'd1;
  end

  // A VALUE write pre-empts the decrement, so it also suppresses the 1->0 flag set.
  assign cf_set = tick & enable & (value_q == 24'd1) & ~wr_value;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) countflag <= 1'b0;
    else          countflag <= cf_set | (countflag & ~(rd_ctrl | wr_value));
  end

  always_comb begin
    HRDATA = 32'd0;
    if (rd_act) begin
      case (dp_addr[3:2])
        2'd0:    HRDATA = {15'd0, countflag, 14'd0, tickint, enable};
        2'd1:    HRDATA = {8'd0, load_q};
        2'd2:    HRDATA = {8'd0, value_q};
        default: HRDATA = CALIB_VAL;
      endcase
    end
  end

  assign HRESP = 1'b0;
  assign IRQ   = countflag & tickint;

  logic unused_ok;
  assign unused_ok = &{1'b0, HADDR[31:4], HTRANS[0], HWDATA[31:24], be[3]};

endmodule

// File: tb/tb_ahbl_systick.sv
// Scoreboarded random/directed bench for ahbl_systick against a cycle-level behavioural model.
// Build with AHBL_SYSTICK_WS_EN defined to exercise the read wait-state variant.
module tb_ahbl_systick;

  localparam logic [31:0] CALIB = 32'h4000_1234;
`ifdef AHBL_SYSTICK_WS_EN
  localparam bit WS = 1'b1;
`else
  localparam bit WS = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'd2;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'd0;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [23:0] SYSTICKCLKDIV = 24'd0;
  logic        IRQ;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahbl_systick #(.CALIB_VAL(CALIB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .SYSTICKCLKDIV(SYSTICKCLKDIV), .IRQ(IRQ)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wd_pend = 32'd0;

  // Behavioural model state, in register-map terms.
  bit          m_en = 0, m_ti = 0, m_flag = 0;
  logic [31:0] m_load = 0, m_val = 0, m_pre = 0;
  bit          m_dp_vld = 0, m_dp_wr = 0;
  int          m_dp_addr = 0, m_dp_size = 0, m_rd_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hready_exp();
    return !(m_dp_vld && !m_dp_wr && m_rd_wait != 0);
  endfunction

  function automatic bit rd_now();
    return m_dp_vld && !m_dp_wr && m_rd_wait == 0;
  endfunction

  function automatic bit lane_hit(input int sz, input int a, input int b);
    if (sz == 0) return b == a % 4;
    if (sz == 1) return b / 2 == (a / 2) % 2;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rdata();
    case (m_dp_addr / 4)
      0:       return {15'd0, m_flag, 14'd0, m_ti, m_en};
      1:       return m_load;
      2:       return m_val;
      default: return CALIB;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ti = 0; m_flag = 0; m_load = 0; m_val = 0; m_pre = 0;
    m_dp_vld = 0; m_dp_wr = 0; m_dp_addr = 0; m_dp_size = 0; m_rd_wait = 0;
  endtask

  task automatic model_step();
    bit hr, tick, rd_ctrl, wr, vwr, set;
    logic [31:0] nv;
    hr      = hready_exp();
    rd_ctrl = rd_now() && (m_dp_addr / 4 == 0);
    wr      = m_dp_vld && m_dp_wr;
    vwr     = wr && (m_dp_addr / 4 == 2);
    tick    = (m_pre >= 32'(SYSTICKCLKDIV));
    m_pre   = tick ? 32'd0 : m_pre + 32'd1;
    nv  = m_val;
    set = 1'b0;
    if (tick && m_en) begin
      if (m_val == 0) nv = m_load;
      else begin
        nv  = m_val - 32'd1;
        set = (m_val == 32'd1);
      end
    end
    if (wr) begin
      case (m_dp_addr / 4)
        0: if (lane_hit(m_dp_size, m_dp_addr, 0)) begin
             m_en = HWDATA[0];
             m_ti = HWDATA[1];
           end
        1: for (int b = 0; b < 3; b++)
             if (lane_hit(m_dp_size, m_dp_addr, b)) m_load[8*b +: 8] = HWDATA[8*b +: 8];
        2: begin nv = 32'd0; set = 1'b0; end
        default: ;
      endcase
    end
    m_flag = set || (m_flag && !(rd_ctrl || vwr));
    m_val  = nv;
    if (hr) begin
      m_dp_vld  = HSEL && HTRANS[1];
      m_dp_wr   = HWRITE;
      m_dp_addr = int'(HADDR[3:0]);
      m_dp_size = int'(HSIZE);
      m_rd_wait = (WS && m_dp_vld && !HWRITE) ? 1 : 0;
    end else begin
      m_rd_wait = 0;
    end
  endtask

  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) model_reset();
    else          model_step();
  end

  // Per-cycle checks; read data expected this cycle goes to the scoreboard.
  initial forever begin
    @(negedge HCLK);
    chk("hreadyout", 32'(HREADYOUT), 32'(hready_exp()));
    chk("irq", 32'(IRQ), 32'(m_flag && m_ti));
    chk("hresp", 32'(HRESP), 32'd0);
    if (rd_now()) exp_q.push_back(exp_rdata());
    else          chk("hrdata_idle", HRDATA, 32'd0);
  end

  // Monitor: follows the bus handshake and pops whenever a read data phase completes.
  initial begin
    bit pend = 1'b0;
    forever begin
      @(negedge HCLK);
      #1;
      if (!HRESETn) pend = 1'b0;
      else begin
        if (pend && HREADYOUT) begin
          if (exp_q.size() == 0) chk("rdata_unexpected", HRDATA, 32'hxxxx_xxxx);
          else                   chk("rdata", HRDATA, exp_q.pop_front());
        end
        if (HREADYOUT) pend = HSEL && HTRANS[1] && !HWRITE;
      end
    end
  end

  task automatic xfer(input bit hs, input logic [1:0] tr, input bit w, input logic [3:0] a,
                      input logic [2:0] sz, input logic [31:0] d);
    bit rdy;
    int n;
    logic [31:0] r;
    r      = $urandom();
    HSEL   = hs;
    HTRANS = tr;
    HADDR  = {r[31:4], a};
    HWRITE = w;
    HSIZE  = sz;
    HWDATA = wd_pend;
    n = 0;
    do begin
      @(negedge HCLK);
      rdy = HREADY;
      @(posedge HCLK);
      #1;
      n++;
    end while (!rdy && n < 8);
    chk("hready_timeout", 32'(rdy), 32'd1);
    wd_pend = d;
  endtask

  task automatic rd(input logic [3:0] a);
    xfer(1'b1, 2'b10, 1'b0, a, 3'd2, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    xfer(1'b1, 2'b10, 1'b1, a, 3'd2, d);
  endtask

  task automatic idle();
    xfer(1'b0, 2'b00, 1'b0, 4'd0, 3'd2, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC); idle();

    // Divide-by-1 countdown 3,2,1,0 with IRQ, then CTRL read clears the flag.
    wr(4'h4, 32'd3); wr(4'h0, 32'd3);
    repeat (7) rd(4'h8);
    rd(4'h0); rd(4'h0); idle();

    // Continuous CTRL reads so one lands on the flag-setting edge.
    wr(4'h4, 32'd2);
    repeat (12) rd(4'h0);
    idle();

    // VALUE write while ticking every cycle.
    wr(4'h8, 32'h0000_0123); rd(4'h8); rd(4'h0);
    wr(4'h8, 32'hFFFF_FFFF); rd(4'h0); idle();

    // Byte and half-word lanes into LOAD.
    wr(4'h0, 32'd0); wr(4'h4, 32'd0);
    xfer(1'b1, 2'b10, 1'b1, 4'h5, 3'd0, 32'h0000_AB00);
    rd(4'h4);
    xfer(1'b1, 2'b11, 1'b1, 4'h6, 3'd1, 32'h5A5A_0000);
    rd(4'h4); idle();

    // Prescaled count, LOAD=0 hold, then back-to-back read/write pairs.
    SYSTICKCLKDIV = 24'd4;
    wr(4'h4, 32'd2); wr(4'h0, 32'd3);
    repeat (20) rd(4'h8);
    wr(4'h4, 32'd0); wr(4'h8, 32'd0);
    repeat (8) rd(4'h8);
    rd(4'h0); wr(4'h4, 32'd1); rd(4'hC); wr(4'h0, 32'd1); idle();

    // Reset in the middle of a LOAD write data phase.
    wr(4'h4, 32'd5); idle();
    xfer(1'b1, 2'b10, 1'b1, 4'h4, 3'd2, 32'h77);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h77;
    #3 HRESETn = 1'b0;
    @(posedge HCLK); @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    wd_pend = 32'd0;
    SYSTICKCLKDIV = 24'd0;
    rd(4'h4); rd(4'h0); rd(4'h8); idle();

    for (int i = 0; i < 400; i++) begin
      int k, rg, sz, off;
      logic [31:0] d;
      if (i % 60 == 0) SYSTICKCLKDIV = 24'($urandom_range(0, 3));
      k   = $urandom_range(0, 9);
      rg  = $urandom_range(0, 3);
      sz  = $urandom_range(0, 2);
      off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      if (k < 4) begin
        xfer(1'b1, 2'($urandom_range(2, 3)), 1'b0, 4'(rg * 4 + off), 3'(sz), 32'd0);
      end else if (k < 7) begin
        d = $urandom();
        if (rg == 1) begin
          sz = 2; off = 0;
          d = 32'($urandom_range(0, 5));
        end else if (rg == 0) begin
          d[0] = ($urandom_range(0, 3) != 0);
        end
        xfer(1'b1, 2'($urandom_range(2, 3)), 1'b1, 4'(rg * 4 + off), 3'(sz), d);
      end else if (k == 7) begin
        xfer(1'b1, 2'b01, 1'($urandom_range(0, 1)), 4'(rg * 4), 3'd2, 32'd0);
      end else if (k == 8) begin
        xfer(1'b0, 2'b10, 1'($urandom_range(0, 1)), 4'(rg * 4), 3'd2, $urandom());
      end else begin
        idle();
      end
    end
    idle(); idle();
    @(negedge HCLK);
    #2;
    chk("rd_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
